// File: rtl/lcd_display_arbiter.sv
// lcd_display_arbiter
//   Shares the 2x16 LCD between three content sources: clock face (src0), settings menu (src1)
//   and alarm banner (src2). Fixed priority 2 > 1 > 0. A granted source is held for at least
//   HOLD_MS before a higher-priority source may preempt it. An alarm banner that is not
//   acknowledged within ALERT_MS is forced off with a one-cycle alert_timeout pulse.
//   LineX[i*8+:8] is character i, with i=0 the leftmost position.
//
//   Optional feature macro: LCD_ARB_BLINK_EN (per-character blinking via blink_a/blink_b).
//
// Ports
//   mclk            main clock
//   rst_n           synchronous reset, active-low
//   req1, req2      menu / alarm display requests (level)
//   ack2            alarm dismiss (1-cycle pulse)
//   a0..b2          line A / line B content of each source
//   blink_a/b       per-char blink masks (LCD_ARB_BLINK_EN only)
//   LineA, LineB    registered lines to lcd_controller
//   grant           one-hot selected source
//   alert_timeout   1-cycle pulse when the alarm banner times out
module lcd_display_arbiter #(
  parameter int unsigned MFREQ_KHZ = 1,
  parameter int unsigned HOLD_MS   = 320,
  parameter int unsigned ALERT_MS  = 5000,
  parameter int unsigned BLINK_MS  = 500
) (
  input  logic         mclk,
  input  logic         rst_n,
  input  logic         req1,
  input  logic         req2,
  input  logic         ack2,
  input  logic [127:0] a0,
  input  logic [127:0] b0,
  input  logic [127:0] a1,
  input  logic [127:0] b1,
  input  logic [127:0] a2,
  input  logic [127:0] b2,
`ifdef LCD_ARB_BLINK_EN
  input  logic [15:0]  blink_a,
  input  logic [15:0]  blink_b,
`endif
  output logic [127:0] LineA,
  output logic [127:0] LineB,
  output logic [2:0]   grant,
  output logic         alert_timeout
);

  localparam logic [127:0] Spaces   = {16{8'h20}};
  localparam logic [15:0]  CycMax   = 16'(MFREQ_KHZ - 1);
  localparam logic [15:0]  HoldMax  = 16'(HOLD_MS);
  localparam logic [15:0]  AlertMax = 16'(ALERT_MS);

  typedef enum logic [1:0] {Show0, Show1, Show2} state_e;

  state_e       state_q, state_d;
  logic [15:0]  cyc_q, cyc_d;
  logic [15:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0]  alert_cnt_q, alert_cnt_d;
  logic         alarm_mask_q, alarm_mask_d;
  logic         tick, eff_req2, hold_done, set_mask, timeout, switching;
  logic [2:0]   grant_d;
  logic [127:0] line_a_d, line_b_d;

`ifdef LCD_ARB_BLINK_EN
  localparam logic [15:0] BlinkMax = 16'(BLINK_MS - 1);
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
`endif

  assign tick      = (cyc_q == CycMax);
  assign eff_req2  = req2 & ~alarm_mask_q;
  assign hold_done = (hold_cnt_q == HoldMax);

  // Next-state decision: upward moves wait for the hold time, fall-backs are immediate.
  always_comb begin
    state_d  = state_q;
    set_mask = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      Show0: begin
        if (hold_done && eff_req2) begin
          state_d = Show2;
        end else if (hold_done && req1) begin
          state_d = Show1;
        end
      end
      Show1: begin
        if (!req1) begin
          state_d = eff_req2 ? Show2 : Show0;
        end else if (eff_req2 && hold_done) begin
          state_d = Show2;
        end
      end
      Show2: begin
        // ack2 (or the alarm going away) beats a coincident timeout: no pulse.
        if (ack2 || !req2) begin
          set_mask = ack2;
          state_d  = req1 ? Show1 : Show0;
        end else if (alert_cnt_q == AlertMax) begin
          set_mask = 1'b1;
          timeout  = 1'b1;
          state_d  = req1 ? Show1 : Show0;
        end
      end
      default: state_d = Show0;
    endcase
  end

  assign switching = (state_d != state_q);

  always_comb begin
    cyc_d        = tick ? 16'd0 : cyc_q + 16'd1;
    hold_cnt_d   = hold_cnt_q;
    alert_cnt_d  = alert_cnt_q;
    if (switching) begin
      hold_cnt_d = 16'd0;
    end else if (tick && !hold_done) begin
      hold_cnt_d = hold_cnt_q + 16'd1;
    end
    if (state_d == Show2 && state_q != Show2) begin
      alert_cnt_d = 16'd0;
    end else if (state_q == Show2 && tick) begin
      alert_cnt_d = alert_cnt_q + 16'd1;
    end
    // The mask lives until the alarm source withdraws its request.
    alarm_mask_d = req2 & (alarm_mask_q | set_mask);
  end

  // Mux on the next grant so the first cycle after a switch already shows the new source.
  always_comb begin
    grant_d  = 3'b001;
    line_a_d = a0;
    line_b_d = b0;
    unique case (state_d)
      Show1: begin
        grant_d  = 3'b010;
        line_a_d = a1;
        line_b_d = b1;
      end
      Show2: begin
        grant_d  = 3'b100;
        line_a_d = a2;
        line_b_d = b2;
      end
      default: begin
        grant_d  = 3'b001;
        line_a_d = a0;
        line_b_d = b0;
      end
    endcase
`ifdef LCD_ARB_BLINK_EN
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (switching) begin
      blink_cnt_d   = 16'd0;
      blink_phase_d = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
    // Blank using the phase that will be registered alongside the line.
    for (int i = 0; i < 16; i++) begin
      if (blink_phase_d && blink_a[i]) line_a_d[i*8+:8] = 8'h20;
      if (blink_phase_d && blink_b[i]) line_b_d[i*8+:8] = 8'h20;
    end
`endif
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q       <= Show0;
      cyc_q         <= 16'd0;
      hold_cnt_q    <= 16'd0;
      alert_cnt_q   <= 16'd0;
      alarm_mask_q  <= 1'b0;
      LineA         <= Spaces;
      LineB         <= Spaces;
      grant         <= 3'b001;
      alert_timeout <= 1'b0;
`ifdef LCD_ARB_BLINK_EN
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      hold_cnt_q    <= hold_cnt_d;
      alert_cnt_q   <= alert_cnt_d;
      alarm_mask_q  <= alarm_mask_d;
      LineA         <= line_a_d;
      LineB         <= line_b_d;
      grant         <= grant_d;
      alert_timeout <= timeout;
`ifdef LCD_ARB_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

endmodule
